prio_arbiter_rr: RTL

Parametrised, registered N-way request arbiter; successor to the 8-to-3 combinational priority encoder.
- Two modes, selected at run time:
  - fixed priority: bit 0 highest, same as the predecessor;
  - round-robin: rotating priority.
- Grant is registered, held stable under a valid/ready handshake, and has a defined value when idle (no X).
- Sits between request sources (DMA channels, interrupt lines) and a shared resource.

---
 rtl/prio_arbiter_rr.sv | 85 ++++++++
 1 files changed

// File: rtl/prio_arbiter_rr.sv
// prio_arbiter_rr: registered N-way arbiter, fixed-priority or round-robin, valid/ready grant.
// Optional grant lock for multi-beat atomic transfers, built when ARB_LOCK_EN is defined.
module prio_arbiter_rr #(
  parameter  int N    = 8,
  localparam int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            mode,
  input  logic            gnt_ready,
`ifdef ARB_LOCK_EN
  input  logic            lock,
`endif
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx,
  output logic [N-1:0]    gnt_onehot,
  output logic [IDXW-1:0] rr_ptr
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]      state;
  logic            gnt_rr, adv;
  logic [N-1:0]    hi_mask, req_hi, base, cand, cand_oh;
  logic [IDXW-1:0] win, ptr_nxt;

  for (genvar i = 0; i < N; i++) begin : g_mask
    assign hi_mask[i] = (IDXW'(i) >= rr_ptr);
  end
  assign req_hi = req & hi_mask;
  // RR: lowest request at or above rr_ptr, else wrap around to the lowest overall.
  assign base = (mode && (req_hi != '0)) ? req_hi : req;

`ifdef ARB_LOCK_EN
  logic locked;
  // While locked only the last granted index may win, and only once it requests again.
  assign cand = locked ? (req & (N'(1) << gnt_idx)) : base;
  assign adv  = gnt_rr & ~locked;
`else
  assign cand = base;
  assign adv  = gnt_rr;
`endif

  assign cand_oh = cand & (~cand + N'(1));

  for (genvar b = 0; b < IDXW; b++) begin : g_enc
    logic [N-1:0] sel;
    for (genvar i = 0; i < N; i++) begin : g_bit
      assign sel[i] = (((i >> b) % 2) == 1);
    end
    assign win[b] = |(cand_oh & sel);
  end

  // Wrap at N, not at 2^IDXW, so non-power-of-two N never yields an out-of-range pointer.
  assign ptr_nxt   = (gnt_idx == IDXW'(N-1)) ? '0 : gnt_idx + IDXW'(1);
  assign gnt_valid = (state == GRANT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      rr_ptr     <= '0;
      gnt_rr     <= 1'b0;
`ifdef ARB_LOCK_EN
      locked     <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (cand != '0) begin
        state      <= GRANT;
        gnt_idx    <= win;
        gnt_onehot <= cand_oh;
        gnt_rr     <= mode;
      end
    end else if (gnt_ready) begin
      state      <= IDLE;
      gnt_onehot <= '0;
      if (adv) rr_ptr <= ptr_nxt;
`ifdef ARB_LOCK_EN
      locked     <= lock;
`endif
    end
  end
endmodule
